// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared widths for the register file and its write-pending scoreboard
package regfile_sb_pkg;
  localparam int RegW = 32;
  localparam int RegAddrBusW = 5;
  localparam int RegNum = 32;
  localparam int SbCntW = 2;
endpackage

// File: rtl/regfile_sb_cnt.sv
// sb_cnt: saturating up/down pending-write counter with clear and error pulses
module sb_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         ovf,
  output logic         unf
);
  assign ovf = inc && !dec && !clr && (cnt == '1);
  assign unf = dec && !inc && !clr && (cnt == '0);
  // clear wins over counting; inc+dec together cancels out
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !dec && cnt != '1) cnt <= cnt + W'(1);
    else if (dec && !inc && cnt != '0) cnt <= cnt - W'(1);
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-through read ports and per-register pending-write scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int NREG = RegNum,
  parameter int CNTW = SbCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rf_we_i,
  input  logic [RegAddrBusW-1:0] rf_wdest_i,
  input  logic [RegW-1:0]        rf_wdata_i,
  input  logic [RegAddrBusW-1:0] rs1_addr_i,
  input  logic [RegAddrBusW-1:0] rs2_addr_i,
  output logic [RegW-1:0]        rs1_data_o,
  output logic [RegW-1:0]        rs2_data_o,
  output logic                   rs1_busy_o,
  output logic                   rs2_busy_o,
  input  logic                   sb_set_i,
  input  logic [RegAddrBusW-1:0] sb_set_dest_i,
  input  logic                   sb_flush_i,
  output logic                   sb_ovf_o,
  output logic                   sb_unf_o,
  input  logic [RegAddrBusW-1:0] dbg_addr_i,
  output logic [RegW-1:0]        dbg_data_o
);
  logic [RegW-1:0] regs [NREG];
  logic [CNTW-1:0] cnt [NREG];
  logic [NREG-1:1] ovf, unf;
  assign cnt[0] = '0;
  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_cnt #(.W(CNTW)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(sb_set_i && sb_set_dest_i == RegAddrBusW'(i)),
      .dec(rf_we_i && rf_wdest_i == RegAddrBusW'(i)),
      .clr(sb_flush_i),
      .cnt(cnt[i]),
      .ovf(ovf[i]),
      .unf(unf[i])
    );
  end
  function automatic logic [RegW-1:0] rd(input logic [RegAddrBusW-1:0] a);
    return a == '0 ? '0 : (rf_we_i && rf_wdest_i == a) ? rf_wdata_i : regs[a];
  endfunction
  function automatic logic busy(input logic [RegAddrBusW-1:0] a);
    return a != '0 && cnt[a] != '0 && !(rf_we_i && rf_wdest_i == a && cnt[a] == CNTW'(1));
  endfunction
  assign rs1_data_o = rd(rs1_addr_i);
  assign rs2_data_o = rd(rs2_addr_i);
  assign rs1_busy_o = busy(rs1_addr_i);
  assign rs2_busy_o = busy(rs2_addr_i);
  assign dbg_data_o = regs[dbg_addr_i];
  // architectural write port; r0 writes are dropped
  always_ff @(posedge clk)
    if (rst) for (int k = 0; k < NREG; k++) regs[k] <= '0;
    else if (rf_we_i && rf_wdest_i != '0) regs[rf_wdest_i] <= rf_wdata_i;
  // sticky scoreboard error flags
  always_ff @(posedge clk)
    if (rst) begin
      sb_ovf_o <= 1'b0;
      sb_unf_o <= 1'b0;
    end else begin
      sb_ovf_o <= sb_ovf_o | (|ovf);
      sb_unf_o <= sb_unf_o | (|unf);
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized scoreboard bench for regfile_sb against an array-based reference model
module tb_regfile_sb;
  logic clk = 0, rst = 0;
  logic rf_we_i = 0, sb_set_i = 0, sb_flush_i = 0;
  logic [4:0] rf_wdest_i = 0, rs1_addr_i = 0, rs2_addr_i = 0, sb_set_dest_i = 0, dbg_addr_i = 0;
  logic [31:0] rf_wdata_i = 0, rs1_data_o, rs2_data_o, dbg_data_o;
  logic rs1_busy_o, rs2_busy_o, sb_ovf_o, sb_unf_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  regfile_sb dut (
    .clk(clk), .rst(rst), .rf_we_i(rf_we_i), .rf_wdest_i(rf_wdest_i), .rf_wdata_i(rf_wdata_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .sb_set_i(sb_set_i), .sb_set_dest_i(sb_set_dest_i),
    .sb_flush_i(sb_flush_i), .sb_ovf_o(sb_ovf_o), .sb_unf_o(sb_unf_o), .dbg_addr_i(dbg_addr_i),
    .dbg_data_o(dbg_data_o)
  );
  typedef struct {
    logic [31:0] d1, d2, dbg;
    logic b1, b2, ovf, unf;
  } exp_t;
  exp_t q[$];
  logic [31:0] regs_m [32];
  int cnt_m [32];
  logic ovf_m = 0, unf_m = 0;
  initial for (int i = 0; i < 32; i++) begin regs_m[i] = 0; cnt_m[i] = 0; end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1_data", rs1_data_o, e.d1);
      chk("rs2_data", rs2_data_o, e.d2);
      chk("rs1_busy", 32'(rs1_busy_o), 32'(e.b1));
      chk("rs2_busy", 32'(rs2_busy_o), 32'(e.b2));
      chk("dbg_data", dbg_data_o, e.dbg);
      chk("sb_ovf", 32'(sb_ovf_o), 32'(e.ovf));
      chk("sb_unf", 32'(sb_unf_o), 32'(e.unf));
    end
  function automatic logic [31:0] m_rd(input logic [4:0] a, input logic we, input logic [4:0] wd, input logic [31:0] wdat);
    if (a == 0) return 0;
    if (we && wd == a) return wdat;
    return regs_m[a];
  endfunction
  function automatic logic m_busy(input logic [4:0] a, input logic we, input logic [4:0] wd);
    return a != 0 && cnt_m[a] != 0 && !(we && wd == a && cnt_m[a] == 1);
  endfunction
  task automatic step(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                      input logic [4:0] a1, input logic [4:0] a2, input logic set, input logic [4:0] sd,
                      input logic fl, input logic r, input logic [4:0] da);
    exp_t e;
    @(posedge clk);
    #1;
    rf_we_i = we; rf_wdest_i = wd; rf_wdata_i = wdat; rs1_addr_i = a1; rs2_addr_i = a2;
    sb_set_i = set; sb_set_dest_i = sd; sb_flush_i = fl; rst = r; dbg_addr_i = da;
    e.d1 = m_rd(a1, we, wd, wdat);
    e.d2 = m_rd(a2, we, wd, wdat);
    e.b1 = m_busy(a1, we, wd);
    e.b2 = m_busy(a2, we, wd);
    e.dbg = regs_m[da];
    e.ovf = ovf_m;
    e.unf = unf_m;
    q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) begin regs_m[i] = 0; cnt_m[i] = 0; end
      ovf_m = 0; unf_m = 0;
    end else begin
      if (we && wd != 0) regs_m[wd] = wdat;
      for (int i = 1; i < 32; i++) begin
        bit inc, dec;
        inc = set && sd == i;
        dec = we && wd == i;
        if (fl) cnt_m[i] = 0;
        else if (inc && !dec) begin
          if (cnt_m[i] == 3) ovf_m = 1; else cnt_m[i]++;
        end else if (dec && !inc) begin
          if (cnt_m[i] == 0) unf_m = 1; else cnt_m[i]--;
        end
      end
    end
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 32; i += 2) step(0, 0, 0, 5'(i), 5'(i + 1), 0, 0, 0, 0, 5'(i));
    step(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 5, 0, 0, 0, 0, 0, 5);
    step(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 7, 7, 1, 7, 0, 0, 7);
    step(0, 0, 0, 7, 0, 1, 7, 0, 0, 7);
    step(0, 0, 0, 7, 0, 1, 7, 0, 0, 7);
    step(1, 7, 32'h1111_0000, 7, 0, 1, 7, 0, 0, 7);
    for (int i = 0; i < 3; i++) step(1, 7, 32'h7000 + i, 7, 7, 0, 0, 0, 0, 7);
    step(0, 0, 0, 7, 9, 0, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 9, 32'h9999_9999, 9, 0, 0, 0, 0, 0, 9);
    step(1, 9, 32'h1234_5678, 9, 0, 1, 9, 0, 0, 9);
    step(0, 0, 0, 9, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    step(1, 3, 32'hAAAA_3333, 3, 4, 0, 0, 1, 0, 3);
    step(0, 0, 0, 3, 4, 0, 0, 0, 0, 3);
    step(1, 6, 32'h6666_6666, 6, 3, 1, 6, 0, 1, 6);
    step(0, 0, 0, 6, 3, 0, 0, 0, 0, 6);
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] msk;
      msk = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'h07;
      step($urandom_range(0, 1) == 1, 5'($urandom) & msk, $urandom,
           5'($urandom) & msk, 5'($urandom) & msk, $urandom_range(0, 1) == 1, 5'($urandom) & msk,
           $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0, 5'($urandom) & msk);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
